// File: rtl/tv80_mcycle_seq.sv
// TV80 M-cycle/T-state sequencer: one-hot MCycle/tstate, IR latch, prefix/ISet, HALT.
// Define TV80_SEQ_WAIT_EN to honour wait_n in T2; otherwise wait_n is ignored.
module tv80_mcycle_seq #(
  parameter int Mode = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cen,
  input  logic       wait_n,
  input  logic [7:0] dinst,
  input  logic       int_req,
  input  logic [2:0] MCycles,
  input  logic [2:0] TStates,
  input  logic [1:0] Prefix,
  input  logic       Halt,
  output logic [6:0] MCycle,
  output logic [6:0] tstate,
  output logic [7:0] IR,
  output logic [1:0] ISet,
  output logic       xy_sel,
  output logic       xy_state,
  output logic       halted,
  output logic       m1_n,
  output logic       inst_done
);

  if (Mode != 0) begin : g_mode_chk
    $error("tv80_mcycle_seq supports only Mode 0 (Z80)");
  end

  logic [2:0] t_idx;
  logic [2:0] m_idx;
  logic [2:0] eff_t;
  logic [2:0] eff_m;
  logic       wait_hold;
  logic       t_end;
  logic       m_last;

`ifdef TV80_SEQ_WAIT_EN
  assign wait_hold = tstate[2] & ~wait_n;
`else
  logic unused_wait_n;
  assign unused_wait_n = wait_n;
  assign wait_hold     = 1'b0;
`endif

  always_comb begin
    t_idx = 3'd0;
    m_idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (tstate[i]) t_idx = 3'(i);
      if (MCycle[i]) m_idx = 3'(i + 1);
    end
  end

  always_comb begin
    if (TStates < 3'd3)
      eff_t = 3'd3;
    else if (TStates == 3'd7)
      eff_t = 3'd6;
    else
      eff_t = TStates;
  end

  assign eff_m = (MCycles == 3'd0) ? 3'd1 : MCycles;

  // ">=" rather than "==" so a decoder that shrinks its answer
  // mid-cycle still terminates instead of running off the vector.
  assign t_end     = ~tstate[0] & (t_idx >= eff_t);
  assign m_last    = m_idx >= eff_m;
  assign inst_done = t_end & m_last;
  assign m1_n      = ~(MCycle[0] & (tstate[1] | tstate[2]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MCycle   <= 7'b0000001;
      tstate   <= 7'b0000001;
      IR       <= 8'h00;
      ISet     <= 2'b00;
      xy_sel   <= 1'b0;
      xy_state <= 1'b0;
      halted   <= 1'b0;
    end else if (cen) begin
      if (tstate[0]) begin
        tstate <= 7'b0000010;
      end else if (!wait_hold) begin
        if (t_end) begin
          tstate <= 7'b0000010;
          if (m_last) begin
            MCycle <= 7'b0000001;
            unique case (Prefix)
              2'b01: ISet <= 2'b01;
              2'b10: ISet <= 2'b10;
              2'b11: begin
                ISet     <= 2'b00;
                xy_state <= 1'b1;
                xy_sel   <= IR[5];
              end
              default: begin
                ISet     <= 2'b00;
                xy_state <= 1'b0;
              end
            endcase
            if (int_req)
              halted <= 1'b0;
            else if (Halt)
              halted <= 1'b1;
          end else begin
            MCycle <= MCycle << 1;
          end
        end else begin
          tstate <= tstate << 1;
        end
      end
      if (MCycle[0] && tstate[2] && !wait_hold)
        IR <= halted ? 8'h00 : dinst;
    end
  end

endmodule
